// File: rtl/axi_riscv_lrsc_resv_table.sv
// Reservation table for the RISC-V LR/SC AXI adapter: one reservation per AXI ID,
// invalidated by overlapping writes and successful SCs, with a registered SC verdict.
module axi_riscv_lrsc_resv_table #(
  parameter int unsigned       ADDR_W     = 64,
  parameter int unsigned       ID_W       = 4,
  parameter int unsigned       NUM_RES    = 4,
  parameter int unsigned       GRAN_LOG2  = 3,
  parameter logic [ADDR_W-1:0] ADDR_BEGIN = '0,
  parameter logic [ADDR_W-1:0] ADDR_END   = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         lr_valid_i,
  output logic                         lr_ready_o,
  input  logic [ID_W-1:0]              lr_id_i,
  input  logic [ADDR_W-1:0]            lr_addr_i,
  input  logic                         sc_valid_i,
  output logic                         sc_ready_o,
  input  logic [ID_W-1:0]              sc_id_i,
  input  logic [ADDR_W-1:0]            sc_addr_i,
  output logic                         sc_resp_valid_o,
  input  logic                         sc_resp_ready_i,
  output logic                         sc_resp_ok_o,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [ADDR_W-1:0]            wr_addr_i,
  input  logic [7:0]                   wr_len_i,
  input  logic [2:0]                   wr_size_i,
  output logic [$clog2(NUM_RES+1)-1:0] num_res_o
);
  localparam int unsigned GW = ADDR_W - GRAN_LOG2;
  localparam int unsigned RW = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
  localparam int unsigned CW = $clog2(NUM_RES + 1);
  localparam int unsigned SW = ADDR_W + 16;
  localparam logic [RW-1:0] LAST_RANK = RW'(NUM_RES - 1);
  localparam logic [RW-1:0] ONE_R = RW'(1);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [NUM_RES-1:0] valid_q, valid_d;
  logic [ID_W-1:0]    id_q   [NUM_RES];
  logic [ID_W-1:0]    id_d   [NUM_RES];
  logic [GW-1:0]      gran_q [NUM_RES];
  logic [GW-1:0]      gran_d [NUM_RES];
  logic [RW-1:0]      rank_q [NUM_RES];
  logic [RW-1:0]      rank_d [NUM_RES];
  logic               resp_valid_q, resp_ok_q;
  logic [CW-1:0]      num_q, num_d;

  logic               sc_accept, sc_ok;
  logic [SW-1:0]      wr_bytes, wr_last, wr_last_g;
  logic [GW-1:0]      wr_gran_lo, wr_gran_hi, sc_gran, lr_gran;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] lo_diff;
    logic [ADDR_W:0] hi_diff;
    lo_diff = {1'b0, a} - {1'b0, ADDR_BEGIN};
    hi_diff = {1'b0, ADDR_END} - {1'b0, a};
    return !lo_diff[ADDR_W] && !hi_diff[ADDR_W];
  endfunction

  assign lr_ready_o      = 1'b1;
  assign wr_ready_o      = 1'b1;
  assign sc_ready_o      = !resp_valid_q || sc_resp_ready_i;
  assign sc_accept       = sc_valid_i && sc_ready_o;
  assign sc_resp_valid_o = resp_valid_q;
  assign sc_resp_ok_o    = resp_ok_q;
  assign num_res_o       = num_q;
  assign sc_gran         = sc_addr_i[ADDR_W-1:GRAN_LOG2];
  assign lr_gran         = lr_addr_i[ADDR_W-1:GRAN_LOG2];

  // Write span end is computed wide and saturated rather than wrapped.
  assign wr_bytes   = {{(SW-9){1'b0}}, {1'b0, wr_len_i} + 9'd1} << wr_size_i;
  assign wr_last    = {16'h0, wr_addr_i} + wr_bytes - SW'(1);
  assign wr_last_g  = wr_last >> GRAN_LOG2;
  assign wr_gran_lo = wr_addr_i[ADDR_W-1:GRAN_LOG2];
  assign wr_gran_hi = (|wr_last_g[SW-1:GW]) ? '1 : wr_last_g[GW-1:0];

  always_comb begin
    logic [NUM_RES-1:0] v_wr;
    logic [NUM_RES-1:0] v_sc;
    logic [RW-1:0]      crank [NUM_RES];
    logic [CW-1:0]      live;
    logic [CW-1:0]      touch_rank;
    logic               sc_hit, lr_hit, lr_free;
    logic [RW-1:0]      hit_idx, free_idx, old_idx, tgt_idx;

    v_wr = valid_q;
    for (int i = 0; i < NUM_RES; i++)
      if (wr_valid_i && gran_q[i] >= wr_gran_lo && gran_q[i] <= wr_gran_hi)
        v_wr[i] = 1'b0;

    sc_hit = 1'b0;
    for (int i = 0; i < NUM_RES; i++)
      if (v_wr[i] && id_q[i] == sc_id_i && gran_q[i] == sc_gran)
        sc_hit = 1'b1;
    sc_ok = sc_hit && in_range(sc_addr_i);

    v_sc = v_wr;
    if (sc_accept)
      for (int i = 0; i < NUM_RES; i++)
        if (id_q[i] == sc_id_i || (sc_ok && gran_q[i] == sc_gran))
          v_sc[i] = 1'b0;

    // Re-rank surviving entries densely so freed slots leave no gaps.
    live = '0;
    for (int i = 0; i < NUM_RES; i++) begin
      crank[i] = '0;
      for (int j = 0; j < NUM_RES; j++)
        if (v_sc[j] && rank_q[j] < rank_q[i])
          crank[i] = crank[i] + ONE_R;
      if (v_sc[i])
        live = live + ONE_C;
    end

    lr_hit   = 1'b0;
    lr_free  = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    old_idx  = '0;
    for (int i = NUM_RES - 1; i >= 0; i--) begin
      if (v_sc[i] && id_q[i] == lr_id_i) begin
        lr_hit  = 1'b1;
        hit_idx = RW'(i);
      end
      if (!v_sc[i]) begin
        lr_free  = 1'b1;
        free_idx = RW'(i);
      end
      if (v_sc[i] && crank[i] == LAST_RANK)
        old_idx = RW'(i);
    end

    if (lr_hit) begin
      tgt_idx    = hit_idx;
      touch_rank = CW'(crank[hit_idx]);
    end else if (lr_free) begin
      tgt_idx    = free_idx;
      touch_rank = live;
    end else begin
      tgt_idx    = old_idx;
      touch_rank = CW'(LAST_RANK);
    end

    valid_d = v_sc;
    id_d    = id_q;
    gran_d  = gran_q;
    for (int i = 0; i < NUM_RES; i++)
      rank_d[i] = crank[i];
    if (lr_valid_i && in_range(lr_addr_i)) begin
      for (int i = 0; i < NUM_RES; i++) begin
        if (RW'(i) == tgt_idx) begin
          valid_d[i] = 1'b1;
          id_d[i]    = lr_id_i;
          gran_d[i]  = lr_gran;
          rank_d[i]  = '0;
        end else if (v_sc[i] && CW'(crank[i]) < touch_rank) begin
          rank_d[i] = crank[i] + ONE_R;
        end
      end
    end

    num_d = '0;
    for (int i = 0; i < NUM_RES; i++)
      if (valid_d[i])
        num_d = num_d + ONE_C;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      num_q        <= '0;
      for (int i = 0; i < NUM_RES; i++) begin
        id_q[i]   <= '0;
        gran_q[i] <= '0;
        rank_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      gran_q  <= gran_d;
      rank_q  <= rank_d;
      num_q   <= num_d;
      if (sc_accept) begin
        resp_valid_q <= 1'b1;
        resp_ok_q    <= sc_ok;
      end else if (sc_resp_ready_i) begin
        resp_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_riscv_lrsc_resv_table.sv
// Self-checking bench for axi_riscv_lrsc_resv_table: directed scenarios plus random
// traffic compared against a per-ID reservation model with LR timestamps.
module tb_axi_riscv_lrsc_resv_table;
  localparam int ADDR_W    = 64;
  localparam int ID_W      = 4;
  localparam int NUM_RES   = 4;
  localparam int GRAN_LOG2 = 3;
  localparam logic [63:0] RANGE_HI = 64'h0000_0000_FFFF_FFFF;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              lr_valid_i, lr_ready_o;
  logic [ID_W-1:0]   lr_id_i;
  logic [ADDR_W-1:0] lr_addr_i;
  logic              sc_valid_i, sc_ready_o;
  logic [ID_W-1:0]   sc_id_i;
  logic [ADDR_W-1:0] sc_addr_i;
  logic              sc_resp_valid_o, sc_resp_ready_i, sc_resp_ok_o;
  logic              wr_valid_i, wr_ready_o;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [7:0]        wr_len_i;
  logic [2:0]        wr_size_i;
  logic [2:0]        num_res_o;

  int errors = 0;
  int checks = 0;

  // Reference model: at most one reservation per ID, age given by LR timestamp.
  bit          m_valid [16];
  logic [63:0] m_gran  [16];
  int          m_stamp [16];
  int          stamp_ctr = 0;
  bit          exp_rv = 1'b0;
  bit          exp_ok = 1'b0;
  int          exp_num = 0;

  axi_riscv_lrsc_resv_table #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .NUM_RES(NUM_RES), .GRAN_LOG2(GRAN_LOG2),
    .ADDR_BEGIN(64'h0), .ADDR_END(RANGE_HI)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lr_valid_i(lr_valid_i), .lr_ready_o(lr_ready_o), .lr_id_i(lr_id_i), .lr_addr_i(lr_addr_i),
    .sc_valid_i(sc_valid_i), .sc_ready_o(sc_ready_o), .sc_id_i(sc_id_i), .sc_addr_i(sc_addr_i),
    .sc_resp_valid_o(sc_resp_valid_o), .sc_resp_ready_i(sc_resp_ready_i), .sc_resp_ok_o(sc_resp_ok_o),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i),
    .wr_len_i(wr_len_i), .wr_size_i(wr_size_i), .num_res_o(num_res_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit in_rng(input logic [63:0] a);
    return a <= RANGE_HI;
  endfunction

  function automatic int model_count();
    int n;
    n = 0;
    for (int k = 0; k < 16; k++) if (m_valid[k]) n++;
    return n;
  endfunction

  task automatic model_update();
    logic [79:0] last;
    logic [63:0] lo_g, hi_g, sg;
    bit          accept, hit;
    int          victim;
    if (rst_i) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
      exp_rv = 1'b0; exp_ok = 1'b0; exp_num = 0;
      return;
    end
    accept = sc_valid_i && (!exp_rv || sc_resp_ready_i);
    if (wr_valid_i) begin
      last = {16'h0, wr_addr_i} + ((80'(wr_len_i) + 80'd1) << wr_size_i) - 80'd1;
      lo_g = wr_addr_i >> GRAN_LOG2;
      hi_g = (last[79:64] != 16'h0) ? (64'hFFFF_FFFF_FFFF_FFFF >> GRAN_LOG2) : 64'(last >> GRAN_LOG2);
      for (int k = 0; k < 16; k++)
        if (m_valid[k] && m_gran[k] >= lo_g && m_gran[k] <= hi_g) m_valid[k] = 1'b0;
    end
    if (accept) begin
      sg  = sc_addr_i >> GRAN_LOG2;
      hit = in_rng(sc_addr_i) && m_valid[sc_id_i] && m_gran[sc_id_i] == sg;
      m_valid[sc_id_i] = 1'b0;
      if (hit)
        for (int k = 0; k < 16; k++) if (m_gran[k] == sg) m_valid[k] = 1'b0;
      exp_rv = 1'b1;
      exp_ok = hit;
    end else if (sc_resp_ready_i) begin
      exp_rv = 1'b0;
    end
    if (lr_valid_i && in_rng(lr_addr_i)) begin
      if (!m_valid[lr_id_i] && model_count() == NUM_RES) begin
        victim = -1;
        for (int k = 0; k < 16; k++)
          if (m_valid[k] && (victim < 0 || m_stamp[k] < m_stamp[victim])) victim = k;
        m_valid[victim] = 1'b0;
      end
      stamp_ctr++;
      m_valid[lr_id_i] = 1'b1;
      m_gran[lr_id_i]  = lr_addr_i >> GRAN_LOG2;
      m_stamp[lr_id_i] = stamp_ctr;
    end
    exp_num = model_count();
  endtask

  task automatic step();
    model_update();
    @(posedge clk_i);
    #1;
    lr_valid_i = 1'b0;
    sc_valid_i = 1'b0;
    wr_valid_i = 1'b0;
  endtask

  task automatic set_lr(input logic [3:0] id, input logic [63:0] a);
    lr_valid_i = 1'b1; lr_id_i = id; lr_addr_i = a;
  endtask

  task automatic set_sc(input logic [3:0] id, input logic [63:0] a);
    sc_valid_i = 1'b1; sc_id_i = id; sc_addr_i = a;
  endtask

  task automatic set_wr(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size);
    wr_valid_i = 1'b1; wr_addr_i = a; wr_len_i = len; wr_size_i = size;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    sc_resp_ready_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    checks++; if (num_res_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_num: got %0d want 0", num_res_o); end
    checks++; if (sc_resp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rv: got %b want 0", sc_resp_valid_o); end
    checks++; if (sc_resp_ok_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ok: got %b want 0", sc_resp_ok_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_basic_pass();
    do_reset();
    set_lr(4'd1, 64'h1000); step();
    checks++; if (num_res_o !== 3'(exp_num)) begin errors++; $display("[TB] FAIL basic_num_lr: got %0d want %0d", num_res_o, exp_num); end
    set_sc(4'd1, 64'h1004); step();
    checks++; if (sc_resp_valid_o !== exp_rv) begin errors++; $display("[TB] FAIL basic_rv: got %b want %b", sc_resp_valid_o, exp_rv); end
    checks++; if (sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL basic_ok: got %b want %b", sc_resp_ok_o, exp_ok); end
    checks++; if (num_res_o !== 3'(exp_num)) begin errors++; $display("[TB] FAIL basic_num_sc: got %0d want %0d", num_res_o, exp_num); end
    step();
    checks++; if (sc_resp_valid_o !== exp_rv) begin errors++; $display("[TB] FAIL basic_rv_drop: got %b want %b", sc_resp_valid_o, exp_rv); end
  endtask

  task automatic test_write_kill();
    do_reset();
    set_lr(4'd1, 64'h1000); step();
    set_wr(64'h0FF8, 8'd1, 3'd3); step();
    checks++; if (num_res_o !== 3'(exp_num)) begin errors++; $display("[TB] FAIL wrkill_num: got %0d want %0d", num_res_o, exp_num); end
    set_sc(4'd1, 64'h1000); step();
    checks++; if (sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL wrkill_ok: got %b want %b", sc_resp_ok_o, exp_ok); end
  endtask

  task automatic test_evict();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_lr(4'(i), 64'h1000 + 64'(i) * 64'h100); step();
    end
    checks++; if (num_res_o !== 3'(exp_num)) begin errors++; $display("[TB] FAIL evict_num: got %0d want %0d", num_res_o, exp_num); end
    set_sc(4'd0, 64'h1000); step();
    checks++; if (sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL evict_id0_ok: got %b want %b", sc_resp_ok_o, exp_ok); end
    set_sc(4'd4, 64'h1400); step();
    checks++; if (sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL evict_id4_ok: got %b want %b", sc_resp_ok_o, exp_ok); end
    checks++; if (num_res_o !== 3'(exp_num)) begin errors++; $display("[TB] FAIL evict_num_after: got %0d want %0d", num_res_o, exp_num); end
  endtask

  task automatic test_shared_granule();
    do_reset();
    set_lr(4'd2, 64'h2000); step();
    set_lr(4'd3, 64'h2000); step();
    set_sc(4'd2, 64'h2000); step();
    checks++; if (sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL shared_id2_ok: got %b want %b", sc_resp_ok_o, exp_ok); end
    set_sc(4'd3, 64'h2000); step();
    checks++; if (sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL shared_id3_ok: got %b want %b", sc_resp_ok_o, exp_ok); end
    checks++; if (num_res_o !== 3'(exp_num)) begin errors++; $display("[TB] FAIL shared_num: got %0d want %0d", num_res_o, exp_num); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_lr(4'd5, 64'h3000); step();
    set_lr(4'd6, 64'h3100); step();
    sc_resp_ready_i = 1'b0;
    set_sc(4'd5, 64'h3000); step();
    for (int c = 0; c < 3; c++) begin
      set_sc(4'd6, 64'h3100);
      #1;
      checks++; if (sc_ready_o !== (!exp_rv || sc_resp_ready_i)) begin errors++; $display("[TB] FAIL bp_ready_hold: got %b want %b", sc_ready_o, !exp_rv || sc_resp_ready_i); end
      step();
      checks++; if (sc_resp_valid_o !== exp_rv || sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL bp_stable: got %b/%b want %b/%b", sc_resp_valid_o, sc_resp_ok_o, exp_rv, exp_ok); end
    end
    sc_resp_ready_i = 1'b1;
    set_sc(4'd6, 64'h3100);
    #1;
    checks++; if (sc_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_release: got %b want 1", sc_ready_o); end
    step();
    checks++; if (sc_resp_valid_o !== exp_rv || sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL bp_second: got %b/%b want %b/%b", sc_resp_valid_o, sc_resp_ok_o, exp_rv, exp_ok); end
    step();
    checks++; if (sc_resp_valid_o !== exp_rv) begin errors++; $display("[TB] FAIL bp_drain: got %b want %b", sc_resp_valid_o, exp_rv); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_lr(4'd9, 64'h5000); set_wr(64'h5000, 8'd0, 3'd3); step();
    checks++; if (num_res_o !== 3'(exp_num)) begin errors++; $display("[TB] FAIL same_lrwr_num: got %0d want %0d", num_res_o, exp_num); end
    set_sc(4'd9, 64'h5000); step();
    checks++; if (sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL same_lrwr_ok: got %b want %b", sc_resp_ok_o, exp_ok); end
    set_lr(4'd10, 64'h5800); step();
    set_sc(4'd10, 64'h5800); set_wr(64'h5803, 8'd0, 3'd0); step();
    checks++; if (sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL same_scwr_ok: got %b want %b", sc_resp_ok_o, exp_ok); end
    set_lr(4'd1, 64'h6000); step();
    set_sc(4'd1, 64'h6000); set_lr(4'd1, 64'h7000); step();
    checks++; if (sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL same_sclr_ok: got %b want %b", sc_resp_ok_o, exp_ok); end
    checks++; if (num_res_o !== 3'(exp_num)) begin errors++; $display("[TB] FAIL same_sclr_num: got %0d want %0d", num_res_o, exp_num); end
    set_sc(4'd1, 64'h7000); step();
    checks++; if (sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL same_rereserve_ok: got %b want %b", sc_resp_ok_o, exp_ok); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    set_lr(4'd2, 64'h1_0000_0000); step();
    checks++; if (num_res_o !== 3'(exp_num)) begin errors++; $display("[TB] FAIL oor_lr_num: got %0d want %0d", num_res_o, exp_num); end
    set_lr(4'd2, 64'hFFFF_FFF8); step();
    set_sc(4'd2, 64'hFFFF_FFF8); step();
    checks++; if (sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL oor_edge_ok: got %b want %b", sc_resp_ok_o, exp_ok); end
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    set_lr(4'd7, 64'h0); step();
    set_lr(4'd8, 64'h40); step();
    set_wr(64'hFFFF_FFFF_FFFF_FFF8, 8'd255, 3'd7); step();
    checks++; if (num_res_o !== 3'(exp_num)) begin errors++; $display("[TB] FAIL sat_num: got %0d want %0d", num_res_o, exp_num); end
    sc_resp_ready_i = 1'b0;
    set_sc(4'd7, 64'h0); step();
    checks++; if (sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL sat_survivor_ok: got %b want %b", sc_resp_ok_o, exp_ok); end
    set_lr(4'd3, 64'h100); step();
    rst_i = 1'b1; step(); rst_i = 1'b0;
    sc_resp_ready_i = 1'b1;
    checks++; if (num_res_o !== 3'd0) begin errors++; $display("[TB] FAIL midreset_num: got %0d want 0", num_res_o); end
    checks++; if (sc_resp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_rv: got %b want 0", sc_resp_valid_o); end
  endtask

  task automatic test_random();
    logic [63:0] base;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      base = ($urandom_range(0, 9) == 0) ? 64'h2_0000_8000 : 64'h8000;
      if ($urandom_range(0, 1) == 1) set_lr(4'($urandom_range(0, 5)), base + 64'($urandom_range(0, 7)) * 8 + 64'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) set_sc(4'($urandom_range(0, 5)), base + 64'($urandom_range(0, 7)) * 8 + 64'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) set_wr(64'h7FF0 + 64'($urandom_range(0, 96)), 8'($urandom_range(0, 3)), 3'($urandom_range(0, 3)));
      sc_resp_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (sc_ready_o !== (!exp_rv || sc_resp_ready_i)) begin errors++; $display("[TB] FAIL rnd_ready cyc %0d: got %b want %b", n, sc_ready_o, !exp_rv || sc_resp_ready_i); end
      step();
      checks++; if (sc_resp_valid_o !== exp_rv) begin errors++; $display("[TB] FAIL rnd_rv cyc %0d: got %b want %b", n, sc_resp_valid_o, exp_rv); end
      if (exp_rv) begin
        checks++; if (sc_resp_ok_o !== exp_ok) begin errors++; $display("[TB] FAIL rnd_ok cyc %0d: got %b want %b", n, sc_resp_ok_o, exp_ok); end
      end
      checks++; if (num_res_o !== 3'(exp_num)) begin errors++; $display("[TB] FAIL rnd_num cyc %0d: got %0d want %0d", n, num_res_o, exp_num); end
    end
    sc_resp_ready_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1;
    lr_valid_i = 1'b0; lr_id_i = '0; lr_addr_i = '0;
    sc_valid_i = 1'b0; sc_id_i = '0; sc_addr_i = '0;
    sc_resp_ready_i = 1'b1;
    wr_valid_i = 1'b0; wr_addr_i = '0; wr_len_i = '0; wr_size_i = '0;
    #1;
    test_reset();
    test_basic_pass();
    test_write_kill();
    test_evict();
    test_shared_granule();
    test_backpressure();
    test_same_cycle();
    test_out_of_range();
    test_saturate_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
